store_buffer: RTL and testbench

- Posted-write buffer between the MEM pipeline stage and Data_Memory.
- Stores are accepted in the cycle they issue and held in a DEPTH-entry FIFO. They are retired to Data_Memory one per cycle whenever the memory port is not taken by a load.
- Loads have priority on the port. Loads are forwarded from the youngest matching buffered store. A flush request drains the whole buffer before a halt or a context change.

---
 rtl/store_buffer_if.sv | 22 ++
 rtl/store_buffer.sv | 141 ++++++++++++++
 tb/tb_store_buffer.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/store_buffer_if.sv
// CPU-side bus of the store buffer: load/store requests, stall and flush.
// master = CPU (MEM stage), slave = store buffer.
interface store_buffer_if;
   logic        MemWrite;
   logic        MemRead;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        stall;
   logic        flush;
   logic        flush_done;

   modport master (
      output MemWrite, MemRead, addr, wdata, flush,
      input  rdata, stall, flush_done
   );

   modport slave (
      input  MemWrite, MemRead, addr, wdata, flush,
      output rdata, stall, flush_done
   );
endinterface

// File: rtl/store_buffer.sv
// Posted-write buffer between MEM stage and Data_Memory.
// STORE_BUF_FORWARD_EN: forward loads from buffered stores, else stall on hit.
module store_buffer #(
   parameter int DEPTH = 4,
   parameter int PTR_W = 2
) (
   input  logic        clk_i,
   input  logic        rst_i,
   store_buffer_if.slave cpu,
   output logic        mem_MemWrite_o,
   output logic        mem_MemRead_o,
   output logic [31:0] mem_addr_o,
   output logic [31:0] mem_data_o,
   input  logic [31:0] mem_data_i
);

   typedef enum logic {RUN, FLUSH} state_t;

   state_t             state_q, state_d;
   logic [31:0]        addr_q [DEPTH];
   logic [31:0]        data_q [DEPTH];
   logic [DEPTH-1:0]   vld_q;
   logic [PTR_W-1:0]   head_q, tail_q;
   logic [PTR_W:0]     cnt_q, cnt_d;
   logic [31:0]        last_q;
   logic               done_q;

   logic               hit;
   logic [31:0]        hit_data;
   logic [PTR_W-1:0]   idx;
   logic               push, pop, ld_mem, ld_fwd, stall;

   // Youngest matching entry: walk oldest to youngest, last match wins.
   always_comb begin
      hit      = 1'b0;
      hit_data = '0;
      idx      = '0;
      for (int k = 0; k < DEPTH; k++) begin
         idx = head_q + PTR_W'(k);
         if (vld_q[idx] && addr_q[idx] == cpu.addr) begin
            hit      = 1'b1;
            hit_data = data_q[idx];
         end
      end
   end

   // Next state, push/pop and load-service decisions.
   always_comb begin
      state_d = state_q;
      push    = 1'b0;
      pop     = 1'b0;
      ld_mem  = 1'b0;
      ld_fwd  = 1'b0;
      stall   = 1'b0;
      unique case (state_q)
         RUN: begin
            push = cpu.MemWrite;
            if (cpu.MemRead) begin
`ifdef STORE_BUF_FORWARD_EN
               if (hit) ld_fwd = 1'b1;
               else     ld_mem = 1'b1;
`else
               if (hit) stall  = 1'b1;
               else     ld_mem = 1'b1;
`endif
            end
            pop = (cnt_q != '0) && !(ld_fwd || ld_mem);
            if (cpu.flush) state_d = FLUSH;
         end
         FLUSH: begin
            stall = cpu.MemWrite | cpu.MemRead;
            pop   = (cnt_q != '0);
            if (cnt_q <= (PTR_W+1)'(1)) state_d = RUN;
         end
      endcase
      cnt_d = cnt_q + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
   end

   // Output drive; everything is forced low while reset is held.
   always_comb begin
      mem_MemWrite_o  = 1'b0;
      mem_MemRead_o   = 1'b0;
      mem_addr_o      = '0;
      mem_data_o      = '0;
      cpu.rdata       = '0;
      cpu.stall       = 1'b0;
      cpu.flush_done  = 1'b0;
      if (!rst_i) begin
         cpu.stall      = stall;
         cpu.flush_done = done_q;
         cpu.rdata      = last_q;
         if (pop) begin
            mem_MemWrite_o = 1'b1;
            mem_addr_o     = addr_q[head_q];
            mem_data_o     = data_q[head_q];
         end else if (ld_mem) begin
            mem_MemRead_o  = 1'b1;
            mem_addr_o     = cpu.addr;
         end
         if (ld_fwd)      cpu.rdata = hit_data;
         else if (ld_mem) cpu.rdata = mem_data_i;
      end
   end

   // Control state: FSM, pointers, count, valid bits, held load data.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= RUN;
         head_q  <= '0;
         tail_q  <= '0;
         cnt_q   <= '0;
         vld_q   <= '0;
         last_q  <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         done_q  <= (state_q == FLUSH) && (state_d == RUN);
         if (pop) begin
            head_q        <= head_q + 1'b1;
            vld_q[head_q] <= 1'b0;
         end
         // push after pop so a full-buffer swap keeps the slot valid
         if (push) begin
            tail_q        <= tail_q + 1'b1;
            vld_q[tail_q] <= 1'b1;
         end
         if (ld_fwd)      last_q <= hit_data;
         else if (ld_mem) last_q <= mem_data_i;
      end
   end

   // Entry payload storage; contents are qualified by vld_q.
   always_ff @(posedge clk_i) begin
      if (!rst_i && push) begin
         addr_q[tail_q] <= cpu.addr;
         data_q[tail_q] <= cpu.wdata;
      end
   end

endmodule

// File: tb/tb_store_buffer.sv
// Randomized bench for store_buffer against a queue-based reference model.
// Works with or without STORE_BUF_FORWARD_EN defined.
module tb_store_buffer;
   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        mem_we, mem_re;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic [31:0] dmem [64];

   always #5 clk = ~clk;

   store_buffer_if bus ();

   store_buffer #(.DEPTH(DEPTH), .PTR_W(2)) dut (
      .clk_i          (clk),
      .rst_i          (rst),
      .cpu            (bus),
      .mem_MemWrite_o (mem_we),
      .mem_MemRead_o  (mem_re),
      .mem_addr_o     (mem_addr),
      .mem_data_o     (mem_wdata),
      .mem_data_i     (mem_rdata)
   );

   assign mem_rdata = dmem[mem_addr[7:2]];

   always @(posedge clk) begin
      if (mem_we) dmem[mem_addr[7:2]] <= mem_wdata;
   end

   typedef struct {
      logic [31:0] a;
      logic [31:0] d;
   } ent_t;

   ent_t        q[$];
   bit          in_flush;
   bit          done;
   logic [31:0] last;
   logic [31:0] rmem [64];
   int          n_chk = 0;
   int          n_err = 0;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic cycle(input bit r, input bit w, input bit rd,
                        input bit fl, input logic [31:0] a,
                        input logic [31:0] d);
      logic [31:0] e_addr, e_wd, e_rd, hd;
      bit e_we, e_re, e_stall, e_done, pop, push, served, hit;
      rst          = r;
      bus.MemWrite = w;
      bus.MemRead  = rd;
      bus.flush    = fl;
      bus.addr     = a;
      bus.wdata    = d;
      @(negedge clk);
      e_we = 0; e_re = 0; e_stall = 0; e_addr = 0; e_wd = 0;
      e_rd = last; e_done = done;
      pop = 0; push = 0; served = 0; hit = 0; hd = 0;
      if (r) begin
         e_rd = 0;
         e_done = 0;
      end else if (in_flush) begin
         e_stall = w | rd;
         pop = q.size() > 0;
      end else begin
         push = w;
         if (rd) begin
            for (int i = q.size() - 1; i >= 0; i--) begin
               if (q[i].a == a) begin
                  hit = 1;
                  hd = q[i].d;
                  break;
               end
            end
`ifdef STORE_BUF_FORWARD_EN
            if (hit) begin
               e_rd = hd;
               served = 1;
            end
`else
            if (hit) e_stall = 1;
`endif
            if (!hit) begin
               e_re = 1;
               e_addr = a;
               e_rd = rmem[a[7:2]];
               served = 1;
            end
         end
         pop = !served && q.size() > 0;
      end
      if (pop) begin
         e_we = 1;
         e_addr = q[0].a;
         e_wd = q[0].d;
      end
      check("stall", 32'(bus.stall), 32'(e_stall));
      check("flush_done", 32'(bus.flush_done), 32'(e_done));
      check("data_o", bus.rdata, e_rd);
      check("mem_we", 32'(mem_we), 32'(e_we));
      check("mem_re", 32'(mem_re), 32'(e_re));
      check("mem_addr", mem_addr, e_addr);
      check("mem_data", mem_wdata, e_wd);
      if (r) begin
         q.delete();
         in_flush = 0;
         done = 0;
         last = 0;
      end else begin
         done = 0;
         if (pop) begin
            rmem[q[0].a[7:2]] = q[0].d;
            void'(q.pop_front());
         end
         if (push) q.push_back('{a: a, d: d});
         if (served) last = e_rd;
         if (in_flush) begin
            if (q.size() == 0) begin
               in_flush = 0;
               done = 1;
            end
         end else if (fl) begin
            in_flush = 1;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 32'h0, 32'h0);
   endtask

   initial begin
      for (int i = 0; i < 64; i++) begin
         dmem[i] = 32'hC0DE_0000 + 32'(i);
         rmem[i] = 32'hC0DE_0000 + 32'(i);
      end
      in_flush = 0;
      done = 0;
      last = 0;
      rst = 1;
      bus.MemWrite = 0;
      bus.MemRead = 0;
      bus.flush = 0;
      bus.addr = 0;
      bus.wdata = 0;
      cycle(1, 0, 0, 0, 32'h0, 32'h0);
      cycle(1, 0, 0, 0, 32'h0, 32'h0);

      cycle(0, 1, 0, 0, 32'h4, 32'hDEAD_BEEF);
      idle(2);

      cycle(0, 1, 0, 0, 32'h8, 32'h1111_1111);
      cycle(0, 1, 0, 0, 32'h8, 32'h2222_2222);
      for (int i = 0; i < 6; i++) begin
         cycle(0, 0, 1, 0, 32'h8, 32'h0);
         if (!bus.stall && !in_flush && last == 32'h2222_2222) break;
      end
      check("fwd_load_value", last, 32'h2222_2222);
      idle(3);

      cycle(0, 1, 0, 0, 32'h20, 32'hAAAA_0001);
      cycle(0, 1, 0, 0, 32'h24, 32'hAAAA_0002);
      for (int i = 0; i < 3; i++) cycle(0, 0, 1, 0, 32'h10, 32'h0);
      idle(3);

      for (int i = 0; i < DEPTH + 3; i++)
         cycle(0, 1, 0, 0, 32'h40 + 32'(4 * i), 32'h5000_0000 + 32'(i));
      idle(DEPTH + 2);

      for (int i = 0; i < 3; i++)
         cycle(0, 1, 0, 0, 32'h80 + 32'(4 * i), 32'h6000_0000 + 32'(i));
      cycle(0, 0, 0, 1, 32'h0, 32'h0);
      for (int i = 0; i < 8; i++) begin
         cycle(0, 1, 0, 0, 32'h90, 32'h7777_7777);
         if (!in_flush && q.size() > 0) break;
      end
      check("held_store_taken", 32'(q.size() > 0), 32'd1);
      idle(3);

      for (int i = 0; i < 3; i++)
         cycle(0, 1, 0, 0, 32'hA0 + 32'(4 * i), 32'h8000_0000 + 32'(i));
      cycle(0, 0, 0, 1, 32'h0, 32'h0);
      cycle(0, 0, 0, 0, 32'h0, 32'h0);
      cycle(1, 0, 0, 0, 32'h0, 32'h0);
      idle(3);

      for (int n = 0; n < 3000; n++) begin
         int sel;
         bit w, rd, fl, r;
         sel = $urandom_range(99);
         r  = ($urandom_range(199) == 0);
         fl = ($urandom_range(39) == 0);
         w  = sel < 45;
         rd = !w && sel < 80;
         cycle(r, w, rd, fl, 32'(4 * $urandom_range(7)), $urandom);
      end
      idle(DEPTH + 4);
      for (int i = 0; i < 64; i++) check("mem_image", dmem[i], rmem[i]);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
